// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared constants and types for the FIFO stream reader
package fifo_stream_pkg;
    localparam int BUF_DEPTH     = 2;
    localparam int DEFAULT_WIDTH = 9;
    typedef logic [1:0] buf_level_t;
endpackage

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry register queue with head index, usable as a skid buffer
module stream_buf2
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output buf_level_t       count
);
    logic [WIDTH-1:0] entry [BUF_DEPTH];
    logic             head;
    logic             wr_idx;
    // Free slot sits right behind the occupied run; a same-cycle pop frees the head slot itself
    always_comb begin
        wr_idx = head ^ count[0];
        dout   = entry[head];
    end
    // Storage, head pointer and occupancy; clear discards contents without touching data regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            head     <= 1'b0;
            count    <= '0;
        end else if (clr) begin
            head  <= 1'b0;
            count <= '0;
        end else begin
            if (push) entry[wr_idx] <= din;
            if (pop) head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    // Pushing into a full buffer without a simultaneous pop would lose a word
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && !clr && count == buf_level_t'(BUF_DEPTH)));
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a registered-output FIFO pop port into a valid/ready stream
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output buf_level_t       buf_level
);
    logic       inflight;
    logic       pop;
    logic [2:0] demand;
    // Issue a read only if the buffer can absorb it together with any word already in flight
    always_comb begin
        m_valid    = buf_level != '0;
        pop        = m_valid && m_ready;
        demand     = {1'b0, buf_level} + {2'b0, inflight} - {2'b0, pop};
        fifo_rd_en = !rst && !fifo_empty && !flush && demand < 3'(BUF_DEPTH);
    end
    // A read issued this cycle returns data on fifo_dout next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight <= 1'b0;
        else inflight <= fifo_rd_en;
    end
    stream_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (inflight && !flush),
        .pop   (pop),
        .din   (fifo_dout),
        .dout  (m_data),
        .count (buf_level)
    );
endmodule
